button_bank: RTL and testbench

Parametrised N-channel push-button conditioner. It replaces the per-button debouncer, synchronizer and rising-edge chain with one block that synchronises first, then debounces and edge-detects every channel. It adds release pulses, long-press detection and auto-repeat. It sits between board push-buttons and the lab FSMs; all outputs are in the `clk` domain.

---
 rtl/button_bank.sv | 132 +++++++++++++
 tb/tb_button_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// N-channel push-button conditioner: 2-FF synchroniser, debounce, press/release
// edges, and a per-channel hold FSM producing long-press and auto-repeat pulses.
module button_bank #(
  parameter int N           = 4,
  parameter int DB_CYCLES   = 500000,
  parameter int LONG_CYCLES = 50000000,
  parameter int RPT_CYCLES  = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  // Named "released" because "release" is a reserved word in SystemVerilog.
  output logic [N-1:0] released,
  output logic [N-1:0] long_press,
  output logic [N-1:0] rpt
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int RPT_W  = $clog2(RPT_CYCLES);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} hold_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic              s1, s2;
    logic [DB_W-1:0]   db_cnt;
    logic              level_q, press_q, release_q;
    logic              flip;
    hold_t             state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [RPT_W-1:0]  rpt_cnt, rpt_nx;
    logic              long_q, long_nx;
    logic              rpt_q, rpt_pulse_nx;

    // The level flips on the cycle after the counter has reached DB_CYCLES,
    // giving DB_CYCLES+2 cycles from a stable input to the level change.
    assign flip = (s2 != level_q) && (db_cnt == DB_W'(DB_CYCLES));

    always_ff @(posedge clk) begin
      if (rst) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1        <= btn_in[i];
        s2        <= s1;
        press_q   <= flip & ~level_q;
        release_q <= flip & level_q;
        if (s2 == level_q) begin
          db_cnt <= '0;
        end else if (flip) begin
          db_cnt  <= '0;
          level_q <= ~level_q;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    always_comb begin
      state_nx     = state;
      hold_nx      = hold_cnt;
      rpt_nx       = rpt_cnt;
      long_nx      = 1'b0;
      rpt_pulse_nx = 1'b0;
      if (flip && level_q) begin
        // Falling edge wins in every state and suppresses any pending pulse.
        state_nx = IDLE;
        hold_nx  = '0;
        rpt_nx   = '0;
      end else begin
        case (state)
          IDLE: begin
            if (flip) begin
              state_nx     = HELD;
              hold_nx      = '0;
              rpt_pulse_nx = 1'b1;
            end
          end
          HELD: begin
            if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
              state_nx     = REPEAT;
              hold_nx      = '0;
              rpt_nx       = '0;
              long_nx      = 1'b1;
              rpt_pulse_nx = 1'b1;
            end else begin
              hold_nx = hold_cnt + HOLD_W'(1);
            end
          end
          REPEAT: begin
            if (rpt_cnt == RPT_W'(RPT_CYCLES - 1)) begin
              rpt_nx       = '0;
              rpt_pulse_nx = 1'b1;
            end else begin
              rpt_nx = rpt_cnt + RPT_W'(1);
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= IDLE;
        hold_cnt <= '0;
        rpt_cnt  <= '0;
        long_q   <= 1'b0;
        rpt_q    <= 1'b0;
      end else begin
        state    <= state_nx;
        hold_cnt <= hold_nx;
        rpt_cnt  <= rpt_nx;
        long_q   <= long_nx;
        rpt_q    <= rpt_pulse_nx;
      end
    end

    assign level[i]      = level_q;
    assign press[i]      = press_q;
    assign released[i]   = release_q;
    assign long_press[i] = long_q;
    assign rpt[i]        = rpt_q;
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank (N=4, DB=4, LONG=10, RPT=3): scenarios push
// expected events into a queue; a monitor pops and compares them cycle by cycle.
module tb_button_bank;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] level, press, released, long_press, rpt;

  button_bank #(.N(4), .DB_CYCLES(4), .LONG_CYCLES(10), .RPT_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level), .press(press),
    .released(released), .long_press(long_press), .rpt(rpt)
  );

  typedef struct {
    int         cyc;
    logic [3:0] lvl, prs, rel, lng, rp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_no = 0;
  int   t0 = 0;
  int   win = 0;
  int   sid = 0;
  bit   active = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic void ex(int c, logic [3:0] l, logic [3:0] p, logic [3:0] r,
                             logic [3:0] lg, logic [3:0] rp);
    exp_t e;
    e.cyc = c; e.lvl = l; e.prs = p; e.rel = r; e.lng = lg; e.rp = rp;
    exp_q.push_back(e);
  endfunction

  function automatic logic [3:0] stim(int s, int c);
    case (s)
      1, 5:    return 4'b0001;
      2:       return ((c < 2) || (c >= 4 && c < 6)) ? 4'b0010 : 4'b0000;
      3:       return (c <= 7) ? 4'b0100 : 4'b0000;
      4:       return 4'b1111;
      6:       return (c < 20) ? 4'b0001 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  // Monitor: compares whenever a pulse appears or an expected probe falls due.
  always @(negedge clk) begin
    int   r;
    exp_t e;
    r = edge_no - t0;
    if (active && r >= 0 && r <= win) begin
      if ((|{press, released, long_press, rpt}) || (exp_q.size() > 0 && exp_q[0].cyc == r)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event sc=%0d cyc=%0d got lvl=%b prs=%b rel=%b lng=%b rpt=%b required no event",
                   sid, r, level, press, released, long_press, rpt);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != r || level !== e.lvl || press !== e.prs || released !== e.rel ||
              long_press !== e.lng || rpt !== e.rp) begin
            failures++;
            $display("FAIL event sc=%0d cyc=%0d got lvl=%b prs=%b rel=%b lng=%b rpt=%b required cyc=%0d lvl=%b prs=%b rel=%b lng=%b rpt=%b",
                     sid, r, level, press, released, long_press, rpt,
                     e.cyc, e.lvl, e.prs, e.rel, e.lng, e.rp);
          end
        end
      end
    end
  end

  task automatic run(int s, int len);
    sid    = s;
    t0     = edge_no + 1;
    win    = len;
    active = 1;
    for (int c = 0; c <= len; c++) begin
      btn_in = stim(s, c);
      rst    = (s == 5 && (c == 12 || c == 13));
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover sc=%0d got %0d pending (first cyc=%0d) required 0",
               s, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
    active = 0;
    btn_in = 4'b0000;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 4'b0000;
    repeat (3) @(negedge clk);

    // Clean press and hold, including reset state and the edge before latency.
    ex(0,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    ex(5,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    ex(6,  4'h1, 4'h1, 4'h0, 4'h0, 4'h1);
    ex(16, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1);
    ex(19, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    ex(22, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    ex(25, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    ex(28, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    run(1, 30);

    // Bounce shorter than the debounce window is ignored.
    ex(6,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    ex(10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    run(2, 20);

    // Short press: press then release, no long press.
    ex(6,  4'h4, 4'h4, 4'h0, 4'h0, 4'h4);
    ex(14, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
    run(3, 25);

    // All channels together.
    ex(6,  4'hF, 4'hF, 4'h0, 4'h0, 4'hF);
    ex(16, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF);
    ex(19, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
    run(4, 20);

    // Reset mid-hold: outputs cleared, re-press after reset, no release.
    ex(6,  4'h1, 4'h1, 4'h0, 4'h0, 4'h1);
    ex(12, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    ex(13, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    ex(20, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1);
    run(5, 25);

    // Release during REPEAT: repeats stop once the level falls.
    ex(6,  4'h1, 4'h1, 4'h0, 4'h0, 4'h1);
    ex(16, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1);
    ex(19, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    ex(22, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    ex(25, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
    ex(26, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    run(6, 35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
